// File: rtl/ex_stage.sv
// ex_stage: execute stage with single-cycle ALU, iterative shift-add multiplier and registered output slot
module ex_stage #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [11:0]      ctrl_ex,
  input  logic [WIDTH-1:0] a_val,
  input  logic [WIDTH-1:0] b_val,
  input  logic [15:0]      imm,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_d,
  output logic [WIDTH-1:0] out_b,
  output logic             out_wr_rd,
  output logic             out_wb_sel,
  output logic             out_wb_en,
  output logic [4:0]       out_wb_reg,
  output logic             busy
);
  localparam int CW = $clog2(WIDTH);
  typedef enum logic [1:0] {IDLE, MUL, MUL_DONE} state_t;
  state_t state_q, state_d;
  logic [WIDTH-1:0] mcand_q, mplier_q, acc_q, pend_b_q, out_d_q, out_b_q;
  logic [WIDTH-1:0] c_val, alu_res, acc_sum, mul_res, ld_d, ld_b;
  logic [7:0] pend_ctrl_q, out_ctrl_q, ld_ctrl;
  logic [CW-1:0] cnt_q;
  logic out_valid_q, slot_free, accept, last, load_alu, load_mul, load;
  always_comb begin
    slot_free = !out_valid_q || out_ready;
    in_ready = !rst && state_q == IDLE && slot_free;
    accept = in_valid && in_ready;
    c_val = ctrl_ex[11] ? {{(WIDTH-16){imm[15]}}, imm} : b_val;
    alu_res = ctrl_ex[9:8] == 2'd0 ? a_val + c_val :
              ctrl_ex[9:8] == 2'd1 ? a_val - c_val :
              ctrl_ex[9:8] == 2'd2 ? a_val & c_val : a_val | c_val;
    acc_sum = acc_q + (mplier_q[0] ? mcand_q : '0);
    last = cnt_q == CW'(WIDTH-1);
    mul_res = state_q == MUL ? acc_sum : acc_q;
    load_alu = accept && ctrl_ex[10];
    load_mul = slot_free && (state_q == MUL_DONE || (state_q == MUL && last));
    load = load_alu || load_mul;
    ld_d = load_alu ? alu_res : mul_res;
    ld_b = load_alu ? b_val : pend_b_q;
    ld_ctrl = load_alu ? ctrl_ex[7:0] : pend_ctrl_q;
    state_d = state_q == IDLE ? (accept && !ctrl_ex[10] ? MUL : IDLE) :
              state_q == MUL ? (last ? (slot_free ? IDLE : MUL_DONE) : MUL) :
              (slot_free ? IDLE : MUL_DONE);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      mcand_q <= '0;
      mplier_q <= '0;
      acc_q <= '0;
      cnt_q <= '0;
      pend_b_q <= '0;
      pend_ctrl_q <= '0;
      out_valid_q <= 1'b0;
      out_d_q <= '0;
      out_b_q <= '0;
      out_ctrl_q <= '0;
    end else begin
      state_q <= state_d;
      if (accept && !ctrl_ex[10]) begin
        mcand_q <= a_val;
        mplier_q <= c_val;
        acc_q <= '0;
        cnt_q <= '0;
        pend_b_q <= b_val;
        pend_ctrl_q <= ctrl_ex[7:0];
      end else if (state_q == MUL) begin
        acc_q <= acc_sum;
        mcand_q <= mcand_q << 1;
        mplier_q <= mplier_q >> 1;
        cnt_q <= cnt_q + CW'(1);
      end
      out_valid_q <= load || (out_valid_q && !out_ready);
      if (load) begin
        out_d_q <= ld_d;
        out_b_q <= ld_b;
        out_ctrl_q <= ld_ctrl;
      end
    end
  end
  assign out_valid = out_valid_q;
  assign out_d = out_d_q;
  assign out_b = out_b_q;
  assign out_wr_rd = out_ctrl_q[7];
  assign out_wb_sel = out_ctrl_q[6];
  assign out_wb_en = out_ctrl_q[5];
  assign out_wb_reg = out_ctrl_q[4:0];
  assign busy = state_q != IDLE;
endmodule

// File: doc/ex_stage.md
# ex_stage

Execute stage of the pipelined CPU, directly downstream of the instruction decoder. Accepts one decoded instruction per handshake (12-bit `ctrl_ex` bundle, register-file operand values, 16-bit immediate) and computes the D result. D comes from a single-cycle ALU (add/sub/and/or) or from an iterative shift-add multiplier. The result, store data and write-back control are held in a registered output slot for the memory stage, with valid/ready backpressure in both directions.

## Interface
- `WIDTH`, 32: datapath width; multiply takes exactly `WIDTH` cycles.
- `clk`  in  1  clock, rising edge.
- `rst`  in  1  one clock; reset is synchronous and active-high.
- `in_valid`  in  1  upstream instruction present.
- `in_ready`  out  1  stage accepts this cycle; transfer when `in_valid && in_ready` at a rising edge.
- `ctrl_ex`  in  12  {c_sel[11], d_sel[10], op_sel[9:8], wr_rd[7], wb_sel[6], write_back_en[5], write_back_reg[4:0]}.
- `a_val`  in  WIDTH  operand A (rs value).
- `b_val`  in  WIDTH  operand B (rt value); also store data.
- `imm`  in  16  immediate, sign-extended to WIDTH.
- `out_valid`  out  1  output slot full.
- `out_ready`  in  1  downstream consumes; transfer when `out_valid && out_ready`.
- `out_d`  out  WIDTH  ALU/MUL result (memory address for LW/SW).
- `out_b`  out  WIDTH  registered `b_val`.
- `out_wr_rd`, `out_wb_sel`, `out_wb_en`  out  1 each  registered ctrl bits 7, 6, 5.
- `out_wb_reg`  out  5  registered ctrl bits 4:0.
- `busy`  out  1  multiplier state active (MUL or MUL_DONE).

## Operation
- C operand = c_sel ? sext(imm) : b_val.
- d_sel=1: ALU on A and C; op_sel 0 = A+C, 1 = A−C, 2 = A&C, 3 = A|C.
- d_sel=0: low WIDTH bits of A×C; op_sel is ignored.
- All arithmetic is modulo 2^WIDTH. No overflow or carry flags. Signed and unsigned give identical low-word results.
- Noop bundles (write_back_en=0, wr_rd=1) are processed like any other instruction. They are not filtered.
- FSM states:
  - IDLE: ALU ops complete here.
  - MUL: multiplier iterating.
  - MUL_DONE: product ready, waiting for the output slot.
- `in_ready` = !rst && state==IDLE && (!out_valid || out_ready).
- ALU accept (IDLE):
  - out_d, out_b and the ctrl fields are loaded at the accept edge.
  - out_valid is set at that edge.
  - State stays IDLE.
- MUL accept (IDLE → MUL):
  - Load mcand=A, mplier=C, acc=0, cnt=0.
  - Latch b_val and the ctrl fields into a pending buffer.
  - out_valid is unaffected, so the previous result may still drain.
- Each MUL cycle:
  - If mplier[0], acc += mcand.
  - Then mcand <<= 1, mplier >>= 1, cnt++.
  - The cycle where cnt == WIDTH−1 is the final iteration.
- End of final iteration:
  - If the slot is free (!out_valid || out_ready): write acc and the pending buffer to the outputs, set out_valid, go to IDLE.
  - Otherwise go to MUL_DONE and hold acc.
- MUL_DONE: on the first edge where the slot is free, write the outputs, set out_valid, go to IDLE.
- Output slot:
  - Clears (out_valid=0) on a consume with no simultaneous load.
  - A consume and a load on the same edge replaces the contents; out_valid stays 1.
- Reset values:
  - out_valid=0, out_d=0, out_b=0, out_wr_rd=0, out_wb_sel=0, out_wb_en=0, out_wb_reg=0, busy=0.
  - State IDLE; cnt, acc and the pending buffer are 0.
  - in_ready=0 while rst is high.

## Timing
- ALU latency: 1. Accept at edge T, out_valid high after edge T.
- Throughput: one ALU op per cycle with out_ready held 1.
- MUL latency: WIDTH. Accept at edge T, out_valid high after edge T+WIDTH when the slot is free.
- in_ready is low for cycles T+1 … until return to IDLE.
- in_ready depends combinationally on out_ready. No other combinational input→output paths.
- rst asserted mid-MUL: the multiply is aborted; all state and outputs take their reset values at that edge. No partial result is emitted.
- out_valid=1 with out_ready=0: every out_* field holds stable (downstream may sample on any cycle).

## Test plan
- ADD: ctrl_ex=0x4A5, a=7, b=0xFFFFFFFF, out_ready=1 → one cycle later out_valid=1, out_d=6, out_wb_en=1, out_wb_reg=5, out_wb_sel=0.
- LW with negative immediate: ctrl_ex=0xCE9, a=0x100, imm=0xFFFC → out_d=0xFC, out_wb_sel=1, out_wb_reg=9.
- MUL: ctrl_ex=0x0A3, a=0x12345, b=0x100 → out_d=0x01234500 with out_valid rising exactly 32 edges after accept; in_ready=0 and busy=1 in between.
- Streaming: SUB 5−7, AND 0xF0F0&0xFF00, OR 0x1|0x8 on three consecutive cycles with out_ready=1 → out_d = 0xFFFFFFFE, 0xF000, 0x9 on consecutive cycles, with no bubbles.
- Backpressure:
  - ALU op with out_ready=0 → in_ready drops and the output holds for 5 cycles.
  - Raise out_ready with the next op present → first op consumed and second loaded on the same edge; no loss or duplication.
  - MUL completing while the slot is full → enters MUL_DONE and emits after the consume.
- Reset mid-MUL: assert rst at cycle 10 of a multiply → next cycle out_valid=0, busy=0, all outputs 0; after release in_ready=1 and a new ADD completes normally.
